// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage bus master.
// Lane-select patterns and the load sign-extension helper live here.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [3:0] SEL_WORD  = 4'b1111;
    localparam logic [3:0] SEL_BYTE0 = 4'b0001;

    function automatic logic [31:0] sext_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/sign extension for loads.
// Purely combinational; store and load sides take separate offset/size inputs.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic        st_word,
    input  logic [31:0] st_data,
    output logic [3:0]  st_sel,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_offset,
    input  logic        ld_word,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0] ld_lane;

    always_comb begin
        st_sel   = SEL_WORD;
        st_wdata = st_data;
        if (!st_word) begin
            st_sel   = SEL_BYTE0 << st_offset;
            st_wdata = {4{st_data[7:0]}};
        end
    end

    always_comb begin
        ld_lane = ld_rdata[7:0];
        unique case (ld_offset)
            2'd0: ld_lane = ld_rdata[7:0];
            2'd1: ld_lane = ld_rdata[15:8];
            2'd2: ld_lane = ld_rdata[23:16];
            2'd3: ld_lane = ld_rdata[31:24];
            default: ld_lane = ld_rdata[7:0];
        endcase
        ld_data = ld_word ? ld_rdata : sext_byte(ld_lane);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage Wishbone-classic master: one bus transaction per load/store,
// stalling the pipeline until ack/err, then committing results to MEM/WB.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  MemSize_in,
    input  logic                  MemtoReg_in,
    input  logic                  RegWrite_in,
    input  logic [ADDR_WIDTH-1:0] ALU_result_in,
    input  logic [DATA_WIDTH-1:0] rs2_data_in,
    input  logic [4:0]            rd_addr_in,
    output logic                  stall_out,
    output logic                  bus_cyc_o,
    output logic                  bus_stb_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_adr_o,
    output logic [DATA_WIDTH-1:0] bus_dat_o,
    output logic [3:0]            bus_sel_o,
    input  logic [DATA_WIDTH-1:0] bus_dat_i,
    input  logic                  bus_ack_i,
    input  logic                  bus_err_i,
    output logic                  MemtoReg_out,
    output logic                  RegWrite_out,
    output logic [4:0]            rd_addr_out,
    output logic [DATA_WIDTH-1:0] ALU_result_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_err_out
);

    mem_state_t            state_q;
    logic [1:0]            ld_offset_q;
    logic                  ld_word_q;
    logic [DATA_WIDTH-1:0] load_q;
    logic                  access;
    logic                  term;
    logic [3:0]            lane_sel;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_ld_data;

    assign access = MemRead_in | MemWrite_in;
    assign term   = bus_ack_i | bus_err_i;

    // Gated by reset so the stall drops immediately when reset asserts mid-access.
    always_comb begin
        stall_out = 1'b0;
        if (reset) begin
            stall_out = (state_q == BUS) || ((state_q == IDLE) && access);
        end
    end

    // Load extraction uses the offset/size latched at launch, not the live inputs.
    mem_lane_align u_lane_align (
        .st_offset (ALU_result_in[1:0]),
        .st_word   (MemSize_in),
        .st_data   (rs2_data_in),
        .st_sel    (lane_sel),
        .st_wdata  (lane_wdata),
        .ld_offset (ld_offset_q),
        .ld_word   (ld_word_q),
        .ld_rdata  (bus_dat_i),
        .ld_data   (lane_ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            bus_cyc_o      <= 1'b0;
            bus_stb_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_adr_o      <= '0;
            bus_dat_o      <= '0;
            bus_sel_o      <= '0;
            ld_offset_q    <= '0;
            ld_word_q      <= 1'b0;
            load_q         <= '0;
            MemtoReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            rd_addr_out    <= '0;
            ALU_result_out <= '0;
            mem_data_out   <= '0;
            mem_err_out    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    mem_err_out    <= 1'b0;
                    ALU_result_out <= ALU_result_in;
                    if (access) begin
                        bus_cyc_o    <= 1'b1;
                        bus_stb_o    <= 1'b1;
                        bus_we_o     <= MemWrite_in;
                        bus_adr_o    <= {ALU_result_in[ADDR_WIDTH-1:2], 2'b00};
                        bus_dat_o    <= lane_wdata;
                        bus_sel_o    <= lane_sel;
                        ld_offset_q  <= ALU_result_in[1:0];
                        ld_word_q    <= MemSize_in;
                        // Bubble into MEM/WB while the access is outstanding.
                        MemtoReg_out <= 1'b0;
                        RegWrite_out <= 1'b0;
                        rd_addr_out  <= '0;
                        state_q      <= BUS;
                    end else begin
                        MemtoReg_out <= MemtoReg_in;
                        RegWrite_out <= RegWrite_in;
                        rd_addr_out  <= rd_addr_in;
                    end
                end
                BUS: begin
                    if (term) begin
                        bus_cyc_o   <= 1'b0;
                        bus_stb_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        load_q      <= bus_err_i ? '0 : lane_ld_data;
                        mem_err_out <= bus_err_i;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    MemtoReg_out   <= MemtoReg_in;
                    RegWrite_out   <= RegWrite_in & ~mem_err_out;
                    rd_addr_out    <= rd_addr_in;
                    ALU_result_out <= ALU_result_in;
                    mem_data_out   <= load_q;
                    mem_err_out    <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    bus_cyc_o <= 1'b0;
                    bus_stb_o <= 1'b0;
                    bus_we_o  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit plus hand-written
// sequences for pass-through, stray acks and asynchronous reset mid-access.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_in, MemWrite_in, MemSize_in, MemtoReg_in, RegWrite_in;
    logic [31:0] ALU_result_in, rs2_data_in;
    logic [4:0]  rd_addr_in;
    logic        stall_out, bus_cyc_o, bus_stb_o, bus_we_o;
    logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i, bus_err_i;
    logic        MemtoReg_out, RegWrite_out, mem_err_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] ALU_result_out, mem_data_out;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .MemSize_in     (MemSize_in),
        .MemtoReg_in    (MemtoReg_in),
        .RegWrite_in    (RegWrite_in),
        .ALU_result_in  (ALU_result_in),
        .rs2_data_in    (rs2_data_in),
        .rd_addr_in     (rd_addr_in),
        .stall_out      (stall_out),
        .bus_cyc_o      (bus_cyc_o),
        .bus_stb_o      (bus_stb_o),
        .bus_we_o       (bus_we_o),
        .bus_adr_o      (bus_adr_o),
        .bus_dat_o      (bus_dat_o),
        .bus_sel_o      (bus_sel_o),
        .bus_dat_i      (bus_dat_i),
        .bus_ack_i      (bus_ack_i),
        .bus_err_i      (bus_err_i),
        .MemtoReg_out   (MemtoReg_out),
        .RegWrite_out   (RegWrite_out),
        .rd_addr_out    (rd_addr_out),
        .ALU_result_out (ALU_result_out),
        .mem_data_out   (mem_data_out),
        .mem_err_out    (mem_err_out)
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        size;
        logic        m2r;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd_addr;
        logic [3:0]  w;
        logic [31:0] rdata;
        logic        ack;
        logic        err;
        logic [3:0]  e_sel;
        logic [31:0] e_dat;
        logic        e_we;
        logic [31:0] e_mdata;
        logic        e_rw;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_nop();
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        MemSize_in    = 1'b0;
        MemtoReg_in   = 1'b0;
        RegWrite_in   = 1'b0;
        ALU_result_in = 32'h0;
        rs2_data_in   = 32'h0;
        rd_addr_in    = 5'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".cyc"}, 32'(bus_cyc_o), 32'd0);
        check({tag, ".stb"}, 32'(bus_stb_o), 32'd0);
        check({tag, ".we"}, 32'(bus_we_o), 32'd0);
        check({tag, ".stall"}, 32'(stall_out), 32'd0);
        check({tag, ".adr"}, bus_adr_o, 32'd0);
        check({tag, ".dat"}, bus_dat_o, 32'd0);
        check({tag, ".sel"}, 32'(bus_sel_o), 32'd0);
        check({tag, ".regwrite"}, 32'(RegWrite_out), 32'd0);
        check({tag, ".memtoreg"}, 32'(MemtoReg_out), 32'd0);
        check({tag, ".rd"}, 32'(rd_addr_out), 32'd0);
        check({tag, ".alu"}, ALU_result_out, 32'd0);
        check({tag, ".mdata"}, mem_data_out, 32'd0);
        check({tag, ".err"}, 32'(mem_err_out), 32'd0);
    endtask

    // Entered 1 time unit after a rising edge; returns at the same phase.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        MemRead_in    = v.rd;
        MemWrite_in   = v.wr;
        MemSize_in    = v.size;
        MemtoReg_in   = v.m2r;
        RegWrite_in   = v.rw;
        ALU_result_in = v.addr;
        rs2_data_in   = v.wdata;
        rd_addr_in    = v.rd_addr;
        #1;
        check({tag, ".stall_launch"}, 32'(stall_out), 32'd1);
        check({tag, ".cyc_launch"}, 32'(bus_cyc_o), 32'd0);
        for (int i = 0; i <= int'(v.w); i++) begin
            @(posedge clk);
            #1;
            check({tag, ".cyc_bus"}, 32'(bus_cyc_o), 32'd1);
            check({tag, ".stb_bus"}, 32'(bus_stb_o), 32'd1);
            check({tag, ".stall_bus"}, 32'(stall_out), 32'd1);
            if (i == 0) begin
                check({tag, ".adr"}, bus_adr_o, v.addr & 32'hFFFF_FFFC);
                check({tag, ".sel"}, 32'(bus_sel_o), 32'(v.e_sel));
                check({tag, ".dat"}, bus_dat_o, v.e_dat);
                check({tag, ".we"}, 32'(bus_we_o), 32'(v.e_we));
                check({tag, ".bubble_rw"}, 32'(RegWrite_out), 32'd0);
                check({tag, ".bubble_rd"}, 32'(rd_addr_out), 32'd0);
            end
            if (i == int'(v.w)) begin
                bus_ack_i = v.ack;
                bus_err_i = v.err;
                bus_dat_i = v.rdata;
            end
        end
        @(posedge clk);
        #1;
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        bus_dat_i = 32'hCCCC_CCCC;
        #1;
        check({tag, ".stall_done"}, 32'(stall_out), 32'd0);
        check({tag, ".cyc_done"}, 32'(bus_cyc_o), 32'd0);
        check({tag, ".we_done"}, 32'(bus_we_o), 32'd0);
        check({tag, ".err_done"}, 32'(mem_err_out), 32'(v.e_err));
        @(posedge clk);
        #1;
        check({tag, ".regwrite"}, 32'(RegWrite_out), 32'(v.e_rw));
        check({tag, ".memtoreg"}, 32'(MemtoReg_out), 32'(v.m2r));
        check({tag, ".rd"}, 32'(rd_addr_out), 32'(v.rd_addr));
        check({tag, ".alu"}, ALU_result_out, v.addr);
        check({tag, ".mdata"}, mem_data_out, v.e_mdata);
        check({tag, ".err_after"}, 32'(mem_err_out), 32'd0);
        set_nop();
    endtask

    initial begin
        //          rd wr sz m2r rw addr          wdata         rd  w  rdata         ack err sel   dat           we mdata         rw err
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 5'd0, 4'd2,
                    32'h0000_0000, 1'b1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0013, 32'h0000_0000, 5'd5, 4'd0,
                    32'h8011_2233, 1'b1, 1'b0, 4'b1000, 32'h0000_0000, 1'b0, 32'hFFFF_FF80, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0002, 32'h0000_00A5, 5'd0, 4'd1,
                    32'h0000_0000, 1'b1, 1'b0, 4'b0100, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1004, 32'h0000_0000, 5'd10, 4'd1,
                    32'h1234_5678, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2001, 32'h0000_0000, 5'd7, 4'd0,
                    32'h1122_3344, 1'b1, 1'b0, 4'b0010, 32'h0000_0000, 1'b0, 32'h0000_0033, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000, 5'd3, 4'd1,
                    32'hFFFF_FFFF, 1'b0, 1'b1, 4'b1111, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3007, 32'hCAFE_F00D, 5'd0, 4'd0,
                    32'h0000_0000, 1'b1, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0000, 5'd9, 4'd0,
                    32'h7F7F_7F7F, 1'b1, 1'b1, 4'b0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0077, 5'd12, 4'd3,
                    32'h0000_00FE, 1'b1, 1'b0, 4'b0001, 32'h7777_7777, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};

        // Reset with an access pending: every output, stall included, must be 0.
        reset       = 1'b0;
        bus_ack_i   = 1'b0;
        bus_err_i   = 1'b0;
        bus_dat_i   = 32'hCCCC_CCCC;
        set_nop();
        MemRead_in  = 1'b1;
        RegWrite_in = 1'b1;
        #12;
        check_all_zero("reset");
        set_nop();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back accesses: each vector launches in the cycle right after DONE.
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Non-memory stream with stray acks/errs: one-cycle pass-through, no bus activity.
        for (int i = 0; i < 6; i++) begin
            RegWrite_in   = i[0];
            MemtoReg_in   = i[1];
            rd_addr_in    = 5'(i + 1);
            ALU_result_in = 32'h1000_0000 + 32'(i * 3);
            bus_ack_i     = i[0];
            bus_err_i     = i[1];
            #1;
            check("nop.stall", 32'(stall_out), 32'd0);
            @(posedge clk);
            #1;
            check("nop.regwrite", 32'(RegWrite_out), 32'(i[0]));
            check("nop.memtoreg", 32'(MemtoReg_out), 32'(i[1]));
            check("nop.rd", 32'(rd_addr_out), 32'(i + 1));
            check("nop.alu", ALU_result_out, 32'h1000_0000 + 32'(i * 3));
            check("nop.cyc", 32'(bus_cyc_o), 32'd0);
            check("nop.err", 32'(mem_err_out), 32'd0);
            check("nop.mdata_hold", mem_data_out, 32'hFFFF_FFFE);
        end
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        set_nop();

        // Asynchronous reset in the middle of BUS.
        MemRead_in    = 1'b1;
        MemSize_in    = 1'b1;
        RegWrite_in   = 1'b1;
        ALU_result_in = 32'h0000_0500;
        rd_addr_in    = 5'd4;
        @(posedge clk);
        #1;
        check("rst_mid.cyc_before", 32'(bus_cyc_o), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        set_nop();
        @(negedge clk);
        reset = 1'b1;
        // Late ack after release must be ignored.
        bus_ack_i = 1'b1;
        bus_dat_i = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("late_ack.cyc", 32'(bus_cyc_o), 32'd0);
            check("late_ack.stall", 32'(stall_out), 32'd0);
            check("late_ack.err", 32'(mem_err_out), 32'd0);
            check("late_ack.mdata", mem_data_out, 32'd0);
        end
        bus_ack_i = 1'b0;
        bus_dat_i = 32'hCCCC_CCCC;

        // FSM is back in IDLE: a fresh access launches normally.
        run_vec(vecs[1], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
